// File: rtl/row_sep_pkg.sv
// row_sep_pkg: shared constants, FSM state type and row-slice helper for the row separator stream.
// Contents: DEF_PIXEL, DEF_ROW_PIX, DEF_NUM_ROWS default geometry; state_t {IDLE, SEND};
// row_slice(block, k) extracts row k from a default-geometry flattened block.
package row_sep_pkg;
   localparam int DEF_PIXEL    = 8;
   localparam int DEF_ROW_PIX  = 32;
   localparam int DEF_NUM_ROWS = 8;
   localparam int DEF_ROW_W    = DEF_ROW_PIX * DEF_PIXEL;
   localparam int DEF_BLK_W    = DEF_NUM_ROWS * DEF_ROW_W;
   typedef enum logic {IDLE, SEND} state_t;
   function automatic logic [DEF_ROW_W-1:0] row_slice(input logic [DEF_BLK_W-1:0] block, input int k);
      return block[k*DEF_ROW_W +: DEF_ROW_W];
   endfunction
endpackage

// File: rtl/row_sep_sel.sv
// row_sep_sel: combinational NUM_ROWS:1 row multiplexer over a flattened block buffer.
// Ports: i_buf  flattened block (row k at [k*ROW_PIX*PIXEL +: ROW_PIX*PIXEL])
//        i_idx  physical row index
//        o_row  selected row (zero when i_idx is out of range)
module row_sep_sel #(
   parameter int PIXEL    = 8,
   parameter int ROW_PIX  = 32,
   parameter int NUM_ROWS = 8,
   parameter int IDX_W    = $clog2(NUM_ROWS)
)(
   input  logic [NUM_ROWS*ROW_PIX*PIXEL-1:0] i_buf,
   input  logic [IDX_W-1:0]                  i_idx,
   output logic [ROW_PIX*PIXEL-1:0]          o_row
);
   localparam int ROW_W = ROW_PIX * PIXEL;
   always_comb begin
      o_row = '0;
      for (int k = 0; k < NUM_ROWS; k++)
         if (i_idx == IDX_W'(k)) o_row = i_buf[k*ROW_W +: ROW_W];
   end
endmodule

// File: rtl/row_sep_stream.sv
// row_sep_stream: buffers one NUM_ROWS x ROW_PIX block and streams it out one row per valid/ready beat.
// Ports: clk, rst_n (async, active low)
//        in_valid/in_ready handshake for block_in + in_dir (0 = row 0 first, 1 = last row first)
//        out_valid/out_ready handshake for out_row, out_idx (physical row), out_last (final beat)
//        busy = a block is held
// Optional: define ROW_SEP_SUBSAMPLE_EN to add in_sub, which emits only even physical rows.
module row_sep_stream
   import row_sep_pkg::*;
#(
   parameter int PIXEL    = DEF_PIXEL,
   parameter int ROW_PIX  = DEF_ROW_PIX,
   parameter int NUM_ROWS = DEF_NUM_ROWS,
   parameter int IDX_W    = $clog2(NUM_ROWS)
)(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [NUM_ROWS*ROW_PIX*PIXEL-1:0] block_in,
   input  logic                              in_dir,
`ifdef ROW_SEP_SUBSAMPLE_EN
   input  logic                              in_sub,
`endif
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [ROW_PIX*PIXEL-1:0]          out_row,
   output logic [IDX_W-1:0]                  out_idx,
   output logic                              out_last,
   output logic                              busy
);
   localparam int BLK_W = NUM_ROWS * ROW_PIX * PIXEL;
   localparam logic [IDX_W-1:0] LAST_ALL = IDX_W'(NUM_ROWS - 1);
   state_t                 r_state, w_state_nxt;
   logic [BLK_W-1:0]       r_buf;
   logic                   r_dir;
   logic [IDX_W-1:0]       r_cnt;
   logic [IDX_W-1:0]       w_step, w_last_cnt;
   logic                   w_last, w_done, w_load, w_adv;
`ifdef ROW_SEP_SUBSAMPLE_EN
   localparam logic [IDX_W-1:0] LAST_SUB = IDX_W'(NUM_ROWS - 2);
   logic r_sub;
   assign w_step     = r_sub ? IDX_W'(2) : IDX_W'(1);
   assign w_last_cnt = r_sub ? LAST_SUB : LAST_ALL;
`else
   assign w_step     = IDX_W'(1);
   assign w_last_cnt = LAST_ALL;
`endif
   always_comb begin
      w_last      = (r_state == SEND) && (r_cnt == w_last_cnt);
      w_done      = w_last && out_ready;
      // Accepting on the last transfer lets a new block follow without a gap.
      in_ready    = (r_state == IDLE) || w_done;
      w_load      = in_valid && in_ready;
      w_adv       = (r_state == SEND) && out_ready && !w_last;
      w_state_nxt = w_load ? SEND : w_done ? IDLE : r_state;
      out_valid   = (r_state == SEND);
      busy        = (r_state == SEND);
      out_last    = w_last;
      // Reverse order counts down from the last emitted row (highest even row when subsampling).
      out_idx     = r_dir ? w_last_cnt - r_cnt : r_cnt;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_buf   <= '0;
         r_dir   <= 1'b0;
         r_cnt   <= '0;
`ifdef ROW_SEP_SUBSAMPLE_EN
         r_sub   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_buf <= block_in;
            r_dir <= in_dir;
            r_cnt <= '0;
`ifdef ROW_SEP_SUBSAMPLE_EN
            r_sub <= in_sub;
`endif
         end else if (w_adv) begin
            r_cnt <= r_cnt + w_step;
         end
      end
   end
   row_sep_sel #(
      .PIXEL(PIXEL), .ROW_PIX(ROW_PIX), .NUM_ROWS(NUM_ROWS), .IDX_W(IDX_W)
   ) u_sel (
      .i_buf(r_buf), .i_idx(out_idx), .o_row(out_row)
   );
endmodule

// File: tb/tb_row_sep_stream.sv
// tb_row_sep_stream: directed self-checking bench for row_sep_stream (default geometry 8 x 32 x 8 bit).
module tb_row_sep_stream;
   localparam int ROW_W = 256;
   localparam int BLK_W = 2048;
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [BLK_W-1:0] block_in = '0;
   logic             in_dir = 1'b0;
`ifdef ROW_SEP_SUBSAMPLE_EN
   logic             in_sub = 1'b0;
`endif
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ROW_W-1:0] out_row;
   logic [2:0]       out_idx;
   logic             out_last;
   logic             busy;
   int               n_chk = 0;
   int               n_fail = 0;
   logic [BLK_W-1:0] blk_a, blk_b;
   logic [ROW_W-1:0] xor_b;
   row_sep_stream dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .block_in(block_in), .in_dir(in_dir),
`ifdef ROW_SEP_SUBSAMPLE_EN
      .in_sub(in_sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
      .out_idx(out_idx), .out_last(out_last), .busy(busy)
   );
   always #5 clk = ~clk;
   function automatic logic [ROW_W-1:0] mk_row(input int base);
      logic [ROW_W-1:0] r;
      for (int p = 0; p < 32; p++) r[p*8 +: 8] = 8'(base + p / 8);
      return r;
   endfunction
   task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic load(input logic [BLK_W-1:0] b, input logic dir);
      block_in = b;
      in_dir   = dir;
      in_valid = 1'b1;
      check("in_ready_idle", ROW_W'(in_ready), ROW_W'(1));
      tick();
      in_valid = 1'b0;
   endtask
   initial begin
      int n, cyc;
      logic stall;
      logic [ROW_W-1:0] h_row;
      logic [2:0] h_idx;
      for (int b = 0; b < 256; b++) begin
         blk_a[b*8 +: 8] = 8'(b / 8);
         blk_b[b*8 +: 8] = 8'(b / 8) ^ 8'hA0;
      end
      for (int p = 0; p < 32; p++) xor_b[p*8 +: 8] = 8'hA0;
      #12;
      check("rst_out_valid", ROW_W'(out_valid), '0);
      check("rst_busy", ROW_W'(busy), '0);
      check("rst_out_row", out_row, '0);
      rst_n = 1'b1;
      tick();
      // 1: reset mid-block
      out_ready = 1'b1;
      load(blk_a, 1'b0);
      tick(); tick(); tick();
      check("pre_rst_idx", ROW_W'(out_idx), ROW_W'(3));
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", ROW_W'(out_valid), '0);
      check("mid_rst_row", out_row, '0);
      check("mid_rst_idx", ROW_W'(out_idx), '0);
      check("mid_rst_last", ROW_W'(out_last), '0);
      check("mid_rst_busy", ROW_W'(busy), '0);
      tick();
      #2 rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", ROW_W'(in_ready), ROW_W'(1));
      for (int i = 0; i < 3; i++) begin
         check("post_rst_no_beat", ROW_W'(out_valid), '0);
         tick();
      end
      // 2: top-down at full rate
      load(blk_a, 1'b0);
      check("td_beat0_row", out_row, {{8{8'h03}}, {8{8'h02}}, {8{8'h01}}, {8{8'h00}}});
      for (int i = 0; i < 8; i++) begin
         check("td_valid", ROW_W'(out_valid), ROW_W'(1));
         check("td_idx", ROW_W'(out_idx), ROW_W'(i));
         check("td_row", out_row, mk_row(4 * i));
         check("td_last", ROW_W'(out_last), ROW_W'(i == 7));
         if (i == 7) check("td_beat7_row", out_row, {{8{8'h1f}}, {8{8'h1e}}, {8{8'h1d}}, {8{8'h1c}}});
         tick();
      end
      check("td_idle_after", ROW_W'(out_valid), '0);
      // 3: bottom-up
      load(blk_a, 1'b1);
      check("bu_first_row", out_row, {{8{8'h1f}}, {8{8'h1e}}, {8{8'h1d}}, {8{8'h1c}}});
      for (int i = 0; i < 8; i++) begin
         check("bu_idx", ROW_W'(out_idx), ROW_W'(7 - i));
         check("bu_row", out_row, mk_row(4 * (7 - i)));
         check("bu_last", ROW_W'(out_last), ROW_W'(i == 7));
         tick();
      end
      check("bu_idle_after", ROW_W'(out_valid), '0);
      // 4: random backpressure
      load(blk_a, 1'b0);
      n = 0;
      stall = 1'b0;
      h_row = '0;
      h_idx = '0;
      cyc = 0;
      while (n < 8 && cyc < 200) begin
         if (stall) begin
            check("stall_row_held", out_row, h_row);
            check("stall_idx_held", ROW_W'(out_idx), ROW_W'(h_idx));
         end
         out_ready = (cyc == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         #1;
         stall = out_valid && !out_ready;
         h_row = out_row;
         h_idx = out_idx;
         if (out_valid && out_ready) begin
            check("bp_idx", ROW_W'(out_idx), ROW_W'(n));
            check("bp_row", out_row, mk_row(4 * n));
            check("bp_last", ROW_W'(out_last), ROW_W'(n == 7));
            n++;
         end
         tick();
         cyc++;
      end
      check("bp_transfers", ROW_W'(n), ROW_W'(8));
      check("bp_idle_after", ROW_W'(out_valid), '0);
      // 5: back-to-back blocks with in_valid held
      out_ready = 1'b1;
      block_in  = blk_a;
      in_dir    = 1'b0;
      in_valid  = 1'b1;
      tick();
      block_in  = blk_b;
      for (int i = 0; i < 16; i++) begin
         check("b2b_valid", ROW_W'(out_valid), ROW_W'(1));
         check("b2b_idx", ROW_W'(out_idx), ROW_W'(i % 8));
         check("b2b_row", out_row, (i < 8) ? mk_row(4 * i) : mk_row(4 * (i - 8)) ^ xor_b);
         check("b2b_in_ready", ROW_W'(in_ready), ROW_W'(i == 7 || i == 15));
         tick();
         if (i == 7) in_valid = 1'b0;
      end
      check("b2b_idle_after", ROW_W'(out_valid), '0);
`ifdef ROW_SEP_SUBSAMPLE_EN
      // 6: subsampled even rows
      in_sub = 1'b1;
      load(blk_a, 1'b0);
      in_sub = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("sub_idx", ROW_W'(out_idx), ROW_W'(2 * i));
         check("sub_row", out_row, mk_row(8 * i));
         check("sub_last", ROW_W'(out_last), ROW_W'(i == 3));
         tick();
      end
      check("sub_idle_after", ROW_W'(out_valid), '0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
